// File: rtl/tt_um_serial_tx.sv
// Parallel-to-serial transmitter. It captures one word on a valid/ready handshake and shifts it out
// at a programmable bit period, with strobes that drive a downstream universal shift register.
module tt_um_serial_tx #(
    parameter int N = 8
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    input  logic                 ENABLE,
    input  logic [N-1:0]         D,
    input  logic                 DIR,
    input  logic [3:0]           BAUD_DIV,
    input  logic                 LOAD_VALID,
    output logic                 LOAD_READY,
    output logic                 S_OUT,
    output logic                 SHIFT_EN,
    output logic [1:0]           RX_CTRL,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [$clog2(N)-1:0] BIT_CNT
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t state, state_next;

    logic [N-1:0]  word_q;
    logic          dir_q;
    logic [3:0]    baud_q;
    logic [3:0]    timer;
    logic [CW-1:0] bit_cnt;
    logic          done_q;

    logic          load_ready;
    logic          shift_en;
    logic          s_out;
    logic          busy;
    logic          handshake;
    logic          last_bit;
    logic [CW-1:0] bit_idx;

    assign handshake = LOAD_VALID && load_ready;
    assign last_bit  = shift_en && (bit_cnt == LAST);
    assign bit_idx   = dir_q ? bit_cnt : LAST - bit_cnt;

    // NOTE: reset is sampled only on CLOCK edges and wins over ENABLE, so it lives outside the enable branch.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state <= IDLE;
        end else if (ENABLE) begin
            state <= state_next;
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (handshake) state_next = SHIFT;
            SHIFT:   if (last_bit)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        load_ready = 1'b0;
        shift_en   = 1'b0;
        s_out      = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: load_ready = ENABLE;
            SHIFT: begin
                busy     = 1'b1;
                s_out    = word_q[bit_idx];
                shift_en = ENABLE && (timer == baud_q);
            end
            default: ;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments, so every update sees the values from before the edge.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            word_q  <= '0;
            dir_q   <= 1'b0;
            baud_q  <= '0;
            timer   <= '0;
            bit_cnt <= '0;
            done_q  <= 1'b0;
        end else if (ENABLE) begin
            done_q <= last_bit;
            if (handshake) begin
                word_q  <= D;
                dir_q   <= DIR;
                baud_q  <= BAUD_DIV;
                timer   <= '0;
                bit_cnt <= '0;
            end else if (state == SHIFT) begin
                if (timer == baud_q) begin
                    timer   <= '0;
                    bit_cnt <= (bit_cnt == LAST) ? '0 : bit_cnt + CW'(1);
                end else begin
                    timer <= timer + 4'd1;
                end
            end
        end
    end

    // The receiver shifts left (01) for MSB-first frames and right (11) for LSB-first frames.
    assign RX_CTRL    = shift_en ? {dir_q, 1'b1} : 2'b00;
    assign LOAD_READY = load_ready;
    assign SHIFT_EN   = shift_en;
    assign S_OUT      = s_out;
    assign BUSY       = busy;
    assign DONE       = done_q && ENABLE;
    assign BIT_CNT    = bit_cnt;

endmodule

// File: tb/tb_tt_um_serial_tx.sv
// Bench for tt_um_serial_tx. Expected bits and words are queued when a frame is launched.
// A monitor compares them against S_OUT and a model of the receiving universal register.
module tb_tt_um_serial_tx;

    logic       CLOCK = 1'b0;
    logic       RESET;
    logic       ENABLE;
    logic [7:0] D;
    logic       DIR;
    logic [3:0] BAUD_DIV;
    logic       LOAD_VALID;
    logic       LOAD_READY;
    logic       S_OUT;
    logic       SHIFT_EN;
    logic [1:0] RX_CTRL;
    logic       BUSY;
    logic       DONE;
    logic [2:0] BIT_CNT;

    typedef struct packed {
        logic       b;
        logic [1:0] ctrl;
    } exp_bit_t;

    exp_bit_t   bit_q[$];
    logic [7:0] word_q[$];
    logic [7:0] rx_reg = 8'h00;
    int         n_checks = 0;
    int         n_errors = 0;

    tt_um_serial_tx #(.N(8)) dut (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .ENABLE     (ENABLE),
        .D          (D),
        .DIR        (DIR),
        .BAUD_DIV   (BAUD_DIV),
        .LOAD_VALID (LOAD_VALID),
        .LOAD_READY (LOAD_READY),
        .S_OUT      (S_OUT),
        .SHIFT_EN   (SHIFT_EN),
        .RX_CTRL    (RX_CTRL),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .BIT_CNT    (BIT_CNT)
    );

    always #5 CLOCK = ~CLOCK;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: S_OUT against the queued bit, receiver model driven by S_OUT/RX_CTRL.
    always @(negedge CLOCK) begin
        if (!RESET) begin
            if (BUSY) begin
                if (bit_q.size() == 0) begin
                    check("unexpected_busy", 32'd1, 32'd0);
                end else begin
                    check("s_out", S_OUT, bit_q[0].b);
                    if (SHIFT_EN) begin
                        check("rx_ctrl", RX_CTRL, bit_q[0].ctrl);
                        void'(bit_q.pop_front());
                    end
                end
            end else begin
                check("idle_quiet", {SHIFT_EN, S_OUT, RX_CTRL}, 4'b0000);
            end
            case (RX_CTRL)
                2'b01:   rx_reg = {rx_reg[6:0], S_OUT};
                2'b11:   rx_reg = {S_OUT, rx_reg[7:1]};
                default: ;
            endcase
            if (DONE) begin
                if (word_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
                else check("rx_word", rx_reg, word_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic push_frame(input logic [7:0] d, input logic dir);
        exp_bit_t e;
        for (int i = 0; i < 8; i++) begin
            e.b    = dir ? d[i] : d[7-i];
            e.ctrl = dir ? 2'b11 : 2'b01;
            bit_q.push_back(e);
        end
        word_q.push_back(d);
    endtask

    // Returns one edge after the handshake, with LOAD_VALID optionally left high.
    task automatic start_frame(input logic [7:0] d, input logic dir, input logic [3:0] baud,
                               input bit hold_valid);
        int n = 0;
        while (!LOAD_READY && n < 600) begin
            tick();
            n++;
        end
        check("ready_wait", LOAD_READY, 1'b1);
        D          = d;
        DIR        = dir;
        BAUD_DIV   = baud;
        LOAD_VALID = 1'b1;
        push_frame(d, dir);
        tick();
        if (!hold_valid) LOAD_VALID = 1'b0;
    endtask

    // Holds ENABLE low for 5 cycles inside bit exp_bit and checks that nothing moves.
    task automatic freeze(input int exp_bit);
        tick();
        ENABLE = 1'b0;
        repeat (5) begin
            @(negedge CLOCK);
            check("frz_bit_cnt", BIT_CNT, exp_bit);
            check("frz_busy", BUSY, 1'b1);
            check("frz_strobes", {SHIFT_EN, LOAD_READY, DONE, RX_CTRL}, 5'b0);
        end
        tick();
        ENABLE = 1'b1;
    endtask

    // Follows a frame up to its DONE cycle, counting enabled busy cycles and strobe positions.
    task automatic run_frame(input int baud, input int pause_bit);
        int busy_n = 0;
        int shift_n = 0;
        int idle_n = 0;
        bit paused = 1'b0;
        bit done = 1'b0;
        for (int c = 0; c < 600 && !done; c++) begin
            @(negedge CLOCK);
            if (DONE) begin
                done = 1'b1;
            end else if (BUSY) begin
                busy_n++;
                shift_n += int'(SHIFT_EN);
                check("shift_pos", SHIFT_EN, (busy_n % (baud + 1)) == 0);
                if (!paused && int'(BIT_CNT) == pause_bit) begin
                    paused = 1'b1;
                    freeze(pause_bit);
                end
            end else begin
                idle_n++;
            end
        end
        check("frame_done", done, 1'b1);
        check("frame_len", busy_n, 8 * (baud + 1));
        check("shift_count", shift_n, 8);
        check("gap_before_done", idle_n, 0);
    endtask

    initial begin
        int n;
        int done_n;
        RESET      = 1'b1;
        ENABLE     = 1'b1;
        D          = 8'h00;
        DIR        = 1'b0;
        BAUD_DIV   = 4'd0;
        LOAD_VALID = 1'b0;
        repeat (3) tick();
        RESET = 1'b0;
        @(negedge CLOCK);
        check("rst_ready", LOAD_READY, 1'b1);
        check("rst_outputs", {S_OUT, SHIFT_EN, RX_CTRL, BUSY, DONE}, 6'b0);
        check("rst_bit_cnt", BIT_CNT, 3'd0);

        // MSB first, one cycle per bit, then LSB first with four cycles per bit
        start_frame(8'hA5, 1'b0, 4'd0, 1'b0);
        run_frame(0, -1);
        start_frame(8'hA5, 1'b1, 4'd3, 1'b0);
        run_frame(3, -1);
        start_frame(8'h3C, 1'b1, 4'd0, 1'b0);
        run_frame(0, -1);

        // Pause inside bit 3
        start_frame(8'h96, 1'b0, 4'd2, 1'b0);
        run_frame(2, 3);

        // Back-to-back frames: LOAD_VALID stays high and the inputs change mid-frame
        start_frame(8'h3C, 1'b0, 4'd1, 1'b1);
        D        = 8'hC3;
        DIR      = 1'b1;
        BAUD_DIV = 4'd2;
        push_frame(8'hC3, 1'b1);
        run_frame(1, -1);
        check("gap_busy", BUSY, 1'b0);
        check("gap_ready", LOAD_READY, 1'b1);
        tick();
        LOAD_VALID = 1'b0;
        check("b2b_busy", BUSY, 1'b1);
        run_frame(2, -1);

        // Idle with ENABLE low
        tick();
        ENABLE = 1'b0;
        @(negedge CLOCK);
        check("idle_dis_ready", LOAD_READY, 1'b0);
        tick();
        ENABLE = 1'b1;

        // Reset while bit 5 is on the line
        start_frame(8'h5A, 1'b0, 4'd3, 1'b0);
        n = 0;
        do begin
            @(negedge CLOCK);
            n++;
        end while (!(BUSY && BIT_CNT == 3'd5) && n < 200);
        check("reach_bit5", BIT_CNT, 3'd5);
        tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        bit_q.delete();
        word_q.delete();
        @(negedge CLOCK);
        check("abort_busy", BUSY, 1'b0);
        check("abort_s_out", S_OUT, 1'b0);
        check("abort_ready", LOAD_READY, 1'b1);
        check("abort_bit_cnt", BIT_CNT, 3'd0);
        done_n = 0;
        repeat (40) begin
            @(negedge CLOCK);
            done_n += int'(DONE);
        end
        check("abort_no_done", done_n, 0);

        // Recovery after the aborted frame
        start_frame(8'hE1, 1'b1, 4'd1, 1'b0);
        run_frame(1, -1);

        repeat (3) tick();
        check("bits_left", bit_q.size(), 0);
        check("words_left", word_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tt_um_serial_tx.md
TT_UM_SERIAL_TX -- requirements
Module: tt_um_serial_tx

Interface
REQ-001 SHALL have parameter N, default 8, word width; only N=8 is required to be supported.
REQ-002 SHALL have input CLOCK, 1 bit: clock; all state updates on the rising edge.
REQ-003 SHALL have input RESET, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have input ENABLE, 1 bit: clock enable; when low, all state holds.
REQ-005 SHALL have input D, 8 bits: parallel word to transmit.
REQ-006 SHALL have input DIR, 1 bit: 0 = MSB first, 1 = LSB first.
REQ-007 SHALL have input BAUD_DIV, 4 bits: bit period minus one, in enabled cycles.
REQ-008 SHALL have input LOAD_VALID, 1 bit: producer has a word on D.
REQ-009 SHALL have output LOAD_READY, 1 bit: block can accept a word.
REQ-010 SHALL have output S_OUT, 1 bit: serial data, driving the S_IN of a universal shift register.
REQ-011 SHALL have output SHIFT_EN, 1 bit: one-cycle sample strobe per bit.
REQ-012 SHALL have output RX_CTRL, 2 bits: mode for the downstream universal register (00 hold, 01 shift MSB<LSB, 11 shift MSB>LSB).
REQ-013 SHALL have output BUSY, 1 bit: a frame is in progress.
REQ-014 SHALL have output DONE, 1 bit: one-cycle frame-complete pulse.
REQ-015 SHALL have output BIT_CNT, 3 bits: index of the bit currently on S_OUT.

Function
REQ-016 FSM SHALL have two states: IDLE and SHIFT.
REQ-017 LOAD_READY SHALL be 1 exactly when the state is IDLE and ENABLE=1.
REQ-018 Handshake SHALL occur on an edge with LOAD_VALID=1 and LOAD_READY=1, capturing D, DIR and BAUD_DIV into internal registers; the state becomes SHIFT, BIT_CNT becomes 0 and the bit timer becomes 0.
REQ-019 Changes to D, DIR or BAUD_DIV after the handshake SHALL NOT affect the frame in progress.
REQ-020 In SHIFT, S_OUT SHALL equal the captured word bit (7-BIT_CNT) when DIR=0, and bit BIT_CNT when DIR=1.
REQ-021 Each bit SHALL be held for BAUD_DIV+1 enabled cycles; the timer increments on each enabled edge and clears when it equals the captured BAUD_DIV.
REQ-022 SHIFT_EN SHALL be 1 only when state=SHIFT, timer=captured BAUD_DIV and ENABLE=1.
REQ-023 RX_CTRL SHALL be 01 when SHIFT_EN=1 and the captured DIR=0, 11 when SHIFT_EN=1 and the captured DIR=1, and 00 otherwise.
REQ-024 On an edge with SHIFT_EN=1 and BIT_CNT<7, BIT_CNT SHALL increment.
REQ-025 On an edge with SHIFT_EN=1 and BIT_CNT=7, the state SHALL become IDLE, BIT_CNT SHALL become 0, and DONE SHALL be 1 for the following cycle only.
REQ-026 A full frame SHALL last exactly 8*(BAUD_DIV+1) enabled cycles.
REQ-027 In IDLE, S_OUT SHALL be 0 and SHIFT_EN SHALL be 0.
REQ-028 BUSY SHALL be 1 exactly when state=SHIFT.
REQ-029 LOAD_VALID SHALL be ignored while in SHIFT; no word is accepted mid-frame.
REQ-030 A new handshake SHALL be accepted in the DONE cycle, giving a minimum gap of 1 cycle between frames.
REQ-031 With ENABLE=0, the state, timer, BIT_CNT and S_OUT SHALL hold; SHIFT_EN, LOAD_READY and DONE SHALL be 0, and the frame resumes unchanged when ENABLE returns high.

Reset
REQ-032 RESET SHALL be synchronous and active-high, and SHALL take priority over ENABLE and the handshake.
REQ-033 On reset the state SHALL be IDLE and S_OUT, SHIFT_EN, BUSY, DONE, BIT_CNT and the timer SHALL be 0, RX_CTRL SHALL be 00, and the captured registers SHALL be 0.
REQ-034 LOAD_READY SHALL be 1 in the first cycle after reset deassertion when ENABLE=1.
REQ-035 A reset applied mid-frame SHALL abort the frame with no DONE pulse.

Verification
REQ-036 Bench SHALL cover: D=0xA5, DIR=0, BAUD_DIV=0 -> S_OUT=1,0,1,0,0,1,0,1 on 8 consecutive cycles, SHIFT_EN=1 and RX_CTRL=01 on each, DONE=1 on cycle 9.
REQ-037 Bench SHALL cover: D=0xA5, DIR=1, BAUD_DIV=3 -> S_OUT=1,0,1,0,0,1,0,1 with each bit held 4 cycles, SHIFT_EN only on the 4th cycle of each bit, RX_CTRL=11, frame of 32 cycles.
REQ-038 Bench SHALL cover: S_OUT and RX_CTRL driven into the universal register at parallel word 0x3C, both DIR values -> register holds 0x3C after DONE.
REQ-039 Bench SHALL cover: ENABLE low for 5 cycles at BIT_CNT=3 -> all outputs frozen, SHIFT_EN=0, and after resume the remaining bits are correct and the total enabled-cycle count is unchanged.
REQ-040 Bench SHALL cover: RESET at BIT_CNT=5 -> next cycle IDLE, S_OUT=0, BUSY=0, no DONE, LOAD_READY=1.
REQ-041 Bench SHALL cover: LOAD_VALID held high with D changing mid-frame -> no capture until DONE, back-to-back frames separated by exactly 1 cycle.
